mult_sequencer: RTL and testbench

Control unit that sequences a shift-and-add multiplier datapath (operand registers, accumulator, shifting multiplier register) over WIDTH iterations.
- Handshake: start/done/ack toward the requester.
- Datapath strobes: loaddata, add_en, shift_en, driven one iteration at a time from the multiplier LSB the datapath feeds back.
- Replaces the single-shot load-then-run controller with a repeatable, counted, acknowledged sequence.

---
 rtl/mult_sequencer.sv | 118 +++++++++++
 tb/tb_mult_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_sequencer.sv
// Control unit for a shift-and-add multiplier: sequences load, WIDTH test/add and
// shift iterations, then holds done until the requester acknowledges.
module mult_sequencer #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          multiplier_lsb,
    input  logic          ack,
    output logic          loaddata,
    output logic          add_en,
    output logic          shift_en,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] bit_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_TEST  = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE_IDX  = CW'(1);

    state_t        state_q, state_d;
    logic [CW-1:0] bit_count_q, bit_count_d;
    logic          loaddata_q, loaddata_d;
    logic          test_q, test_d;
    logic          shift_en_q, shift_en_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // Next-state, iteration counter and next-state output decode
    always_comb begin
        state_d     = state_q;
        bit_count_d = bit_count_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                state_d     = S_TEST;
                bit_count_d = {CW{1'b0}};
            end
            S_TEST: begin
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                // Counter saturates on the last iteration so it reads WIDTH-1 in S_DONE
                if (bit_count_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    state_d     = S_TEST;
                    bit_count_d = bit_count_q + ONE_IDX;
                end
            end
            S_DONE: begin
                if (ack) begin
                    state_d     = S_IDLE;
                    bit_count_d = {CW{1'b0}};
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                bit_count_d = {CW{1'b0}};
            end
        endcase

        // Outputs are decoded from the next state so the flops track the state register
        loaddata_d = (state_d == S_LOAD);
        test_d     = (state_d == S_TEST);
        shift_en_d = (state_d == S_SHIFT);
        busy_d     = (state_d == S_LOAD) || (state_d == S_TEST) || (state_d == S_SHIFT);
        done_d     = (state_d == S_DONE);
    end

    // State, counter and registered output flops; reset clears all immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            bit_count_q <= {CW{1'b0}};
            loaddata_q  <= 1'b0;
            test_q      <= 1'b0;
            shift_en_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_count_q <= bit_count_d;
            loaddata_q  <= loaddata_d;
            test_q      <= test_d;
            shift_en_q  <= shift_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // add_en must follow the live multiplier LSB during the test cycle
    assign add_en    = test_q & multiplier_lsb;
    assign loaddata  = loaddata_q;
    assign shift_en  = shift_en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign bit_count = bit_count_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer: models the multiplier shift register to feed
// multiplier_lsb and checks strobe counts, latency and handshake behaviour.
module tb_mult_sequencer;

    localparam int WIDTH = 8;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          multiplier_lsb;
    logic          ack;
    logic          loaddata;
    logic          add_en;
    logic          shift_en;
    logic          busy;
    logic          done;
    logic [CW-1:0] bit_count;

    int checks   = 0;
    int failures = 0;

    int edge_cnt = 0;
    int n_load   = 0;
    int n_add    = 0;
    int n_shift  = 0;
    int n_busy   = 0;
    int n_done   = 0;

    logic [7:0] pat  = 8'h00;
    logic [7:0] mreg = 8'h00;

    always #5 clk = ~clk;

    mult_sequencer #(.WIDTH(WIDTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .multiplier_lsb (multiplier_lsb),
        .ack            (ack),
        .loaddata       (loaddata),
        .add_en         (add_en),
        .shift_en       (shift_en),
        .busy           (busy),
        .done           (done),
        .bit_count      (bit_count)
    );

    // Cycle counters for each strobe over the cycle ending at this edge
    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        if (loaddata) n_load  <= n_load + 1;
        if (add_en)   n_add   <= n_add + 1;
        if (shift_en) n_shift <= n_shift + 1;
        if (busy)     n_busy  <= n_busy + 1;
        if (done)     n_done  <= n_done + 1;
    end

    // Advance to the next falling edge and update the modelled multiplier register
    task automatic cyc();
        @(negedge clk);
        if (loaddata) mreg = pat;
        else if (shift_en) mreg = mreg >> 1;
        multiplier_lsb = mreg[0];
    endtask

    task automatic wait_done(input string tag);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            if (done) got = 1'b1;
            else cyc();
        end
        checks++;
        if (got !== 1'b1) begin
            failures++;
            $display("FAIL %s_timeout got=%0d exp=1", tag, got);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b1; ack = 1'b0; multiplier_lsb = 1'b1;
        #1;
        checks++;
        if ({loaddata, add_en, shift_en, busy, done, bit_count} !== 8'd0) begin
            failures++;
            $display("FAIL reset_held got=%b exp=0", {loaddata, add_en, shift_en, busy, done, bit_count});
        end
        repeat (3) cyc();
        reset = 1'b1; start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            checks++;
            if ({loaddata, add_en, shift_en, busy, done, bit_count} !== 8'd0) begin
                failures++;
                $display("FAIL reset_idle_%0d got=%b exp=0", i, {loaddata, add_en, shift_en, busy, done, bit_count});
            end
        end
        checks++;
        if (n_load + n_shift + n_busy + n_done !== 0) begin
            failures++;
            $display("FAIL reset_activity got=%0d exp=0", n_load + n_shift + n_busy + n_done);
        end
    endtask

    task automatic run_op(input logic [7:0] p, input int exp_add, input bit do_ack);
        int e0, l0, a0, s0, b0;
        logic [7:0] mask;
        pat  = p;
        mask = 8'h00;
        l0 = n_load; a0 = n_add; s0 = n_shift; b0 = n_busy;
        e0 = edge_cnt + 1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            if (add_en) mask[bit_count] = 1'b1;
            cyc();
        end
        checks++;
        if (edge_cnt - e0 !== 2 * WIDTH + 1 || done !== 1'b1) begin
            failures++;
            $display("FAIL latency_%h got=%0d exp=%0d", p, edge_cnt - e0, 2 * WIDTH + 1);
        end
        checks++;
        if (n_load - l0 !== 1) begin
            failures++;
            $display("FAIL load_count_%h got=%0d exp=1", p, n_load - l0);
        end
        checks++;
        if (n_shift - s0 !== WIDTH) begin
            failures++;
            $display("FAIL shift_count_%h got=%0d exp=%0d", p, n_shift - s0, WIDTH);
        end
        checks++;
        if (n_add - a0 !== exp_add) begin
            failures++;
            $display("FAIL add_count_%h got=%0d exp=%0d", p, n_add - a0, exp_add);
        end
        checks++;
        if (n_busy - b0 !== 17) begin
            failures++;
            $display("FAIL busy_count_%h got=%0d exp=17", p, n_busy - b0);
        end
        checks++;
        if (mask !== p) begin
            failures++;
            $display("FAIL add_iters_%h got=%h exp=%h", p, mask, p);
        end
        checks++;
        if (bit_count !== 3'd7) begin
            failures++;
            $display("FAIL done_bitcount_%h got=%0d exp=7", p, bit_count);
        end
        if (do_ack) begin
            ack = 1'b1;
            cyc();
            ack = 1'b0;
            checks++;
            if ({done, busy, bit_count} !== 5'd0) begin
                failures++;
                $display("FAIL ack_idle_%h got=%b exp=0", p, {done, busy, bit_count});
            end
        end
    endtask

    task automatic test_done_hold();
        int bad;
        bad = 0;
        ack = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (done !== 1'b1 || bit_count !== 3'd7 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL done_hold got=%0d_bad_cycles exp=0", bad);
        end
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL done_ack got=%b%b exp=00", done, busy);
        end
        cyc();
        checks++;
        if (loaddata !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_ack got=%b%b exp=00", loaddata, busy);
        end
    endtask

    task automatic test_back_to_back();
        int l0;
        pat = 8'h3C;
        l0 = n_load;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 20 && bit_count !== 3'd2; i++) cyc();
        // Pulse start across a TEST and a SHIFT edge
        start = 1'b1;
        cyc();
        cyc();
        start = 1'b0;
        wait_done("ignore");
        start = 1'b1;
        ack = 1'b1;
        cyc();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL start_ack_idle got=%b%b exp=00", done, busy);
        end
        start = 1'b0;
        ack = 1'b0;
        cyc();
        cyc();
        checks++;
        if (n_load - l0 !== 1 || loaddata !== 1'b0) begin
            failures++;
            $display("FAIL start_ignored got=%0d exp=1", n_load - l0);
        end
        // Hold start through a whole operation and across the ack
        l0 = n_load;
        start = 1'b1;
        cyc();
        wait_done("held");
        checks++;
        if (n_load - l0 !== 1) begin
            failures++;
            $display("FAIL held_single_load got=%0d exp=1", n_load - l0);
        end
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        checks++;
        if (loaddata !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL held_idle_gap got=%b%b%b exp=000", loaddata, busy, done);
        end
        cyc();
        checks++;
        if (loaddata !== 1'b1) begin
            failures++;
            $display("FAIL held_second_load got=%b exp=1", loaddata);
        end
        start = 1'b0;
        wait_done("second");
        ack = 1'b1;
        cyc();
        ack = 1'b0;
    endtask

    task automatic test_mid_reset();
        int d0;
        pat = 8'h5A;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 20 && bit_count !== 3'd3; i++) cyc();
        checks++;
        if (bit_count !== 3'd3 || busy !== 1'b1) begin
            failures++;
            $display("FAIL midreset_reach got=%0d exp=3", bit_count);
        end
        d0 = n_done;
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({loaddata, add_en, shift_en, busy, done, bit_count} !== 8'd0) begin
            failures++;
            $display("FAIL midreset_async got=%b exp=0", {loaddata, add_en, shift_en, busy, done, bit_count});
        end
        cyc();
        reset = 1'b1;
        cyc();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || n_done !== d0) begin
            failures++;
            $display("FAIL midreset_abandon got=%b%b exp=00", busy, done);
        end
    endtask

    initial begin
        test_reset();
        run_op(8'hA5, 4, 1'b0);
        test_done_hold();
        test_back_to_back();
        test_mid_reset();
        run_op(8'hFF, 8, 1'b1);
        run_op(8'h00, 0, 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
